// File: rtl/dcache_controller_pkg.sv
// Shared widths, state encoding and address field layout for the direct-mapped data cache.
package dcache_controller_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned N_SETS     = 8;
    localparam int unsigned BLK_WORDS  = 4;
    localparam int unsigned TAG_W      = 3;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned OFF_W      = 2;
    localparam int unsigned MEM_BLK_W  = DATA_W * BLK_WORDS;
    localparam int unsigned MEM_ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        DC_IDLE      = 2'd0,
        DC_WRITEBACK = 2'd1,
        DC_FETCH     = 2'd2
    } dc_state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
    } cpu_addr_t;

    // Selects one CPU word out of a cache line; word0 sits in the low byte.
    function automatic logic [DATA_W-1:0] line_word(input logic [MEM_BLK_W-1:0] line,
                                                    input logic [OFF_W-1:0]     off);
        return line[{off, 3'b000} +: DATA_W];
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signals of the data cache, bundled for port connection.
interface dcache_controller_if;
    import dcache_controller_pkg::*;

    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  busywait;
    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [MEM_BLK_W-1:0]  mem_writedata;
    logic [MEM_BLK_W-1:0]  mem_readdata;
    logic                  mem_busywait;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/dcache_array.sv
// Line storage: data, tags, valid and dirty bits with one combinational read
// and one synchronous port doing either a word write or a full-line fill.
module dcache_array
    import dcache_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     idx,
    input  logic [OFF_W-1:0]     off,
    input  logic                 word_we,
    input  logic [DATA_W-1:0]    word,
    input  logic                 fill_we,
    input  logic [MEM_BLK_W-1:0] fill_line,
    input  logic [TAG_W-1:0]     fill_tag,
    output logic [MEM_BLK_W-1:0] line_c,
    output logic [TAG_W-1:0]     tag_c,
    output logic                 valid_c,
    output logic                 dirty_c
);

    logic [MEM_BLK_W-1:0] data_q [N_SETS];
    logic [MEM_BLK_W-1:0] data_d [N_SETS];
    logic [TAG_W-1:0]     tag_q  [N_SETS];
    logic [TAG_W-1:0]     tag_d  [N_SETS];
    logic [N_SETS-1:0]    valid_q, valid_d;
    logic [N_SETS-1:0]    dirty_q, dirty_d;

    assign line_c  = data_q[idx];
    assign tag_c   = tag_q[idx];
    assign valid_c = valid_q[idx];
    assign dirty_c = dirty_q[idx];

    // A fill takes priority; the controller never raises both in one cycle.
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_we) begin
            data_d[idx]  = fill_line;
            tag_d[idx]   = fill_tag;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end else if (word_we) begin
            data_d[idx][{off, 3'b000} +: DATA_W] = word;
            dirty_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache: hit compare, word mux and the
// IDLE / WRITEBACK / FETCH miss sequencer in front of a multi-cycle memory.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    dcache_controller_if.slave bus
);

    cpu_addr_t            addr;
    dc_state_e            state_q, state_d;
    logic                 first_q, first_d;
    logic                 req_c, hit_c;
    logic                 word_we, fill_we;
    logic [MEM_BLK_W-1:0] line_c;
    logic [TAG_W-1:0]     tag_c;
    logic                 valid_c, dirty_c;

    assign addr  = cpu_addr_t'(bus.address);
    assign req_c = bus.read | bus.write;
    assign hit_c = valid_c && (tag_c == addr.tag);

    dcache_array u_array (
        .clk       (clk),
        .reset     (reset),
        .idx       (addr.idx),
        .off       (addr.off),
        .word_we   (word_we),
        .word      (bus.writedata),
        .fill_we   (fill_we),
        .fill_line (bus.mem_readdata),
        .fill_tag  (addr.tag),
        .line_c    (line_c),
        .tag_c     (tag_c),
        .valid_c   (valid_c),
        .dirty_c   (dirty_c)
    );

    assign bus.readdata = line_word(line_c, addr.off);
    assign bus.busywait = !reset && req_c && !((state_q == DC_IDLE) && hit_c);

    // first_q marks the mandatory wait cycle on entry to a memory state.
    always_comb begin
        state_d           = state_q;
        first_d           = 1'b0;
        word_we           = 1'b0;
        fill_we           = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = {addr.tag, addr.idx};
        bus.mem_writedata = line_c;
        unique case (state_q)
            DC_IDLE: begin
                if (req_c) begin
                    if (hit_c) begin
                        word_we = bus.write;
                    end else if (dirty_c) begin
                        state_d = DC_WRITEBACK;
                        first_d = 1'b1;
                    end else begin
                        state_d = DC_FETCH;
                        first_d = 1'b1;
                    end
                end
            end
            DC_WRITEBACK: begin
                bus.mem_write   = 1'b1;
                bus.mem_address = {tag_c, addr.idx};
                if (!first_q && !bus.mem_busywait) begin
                    state_d = DC_FETCH;
                    first_d = 1'b1;
                end
            end
            DC_FETCH: begin
                bus.mem_read = 1'b1;
                if (!first_q && !bus.mem_busywait) begin
                    fill_we = 1'b1;
                    state_d = DC_IDLE;
                end
            end
            default: state_d = DC_IDLE;
        endcase
        if (reset) begin
            word_we       = 1'b0;
            fill_we       = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DC_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

endmodule
